// File: rtl/ibex_rvfi_trace_buf_if.sv
// ----------------------------------------------------------------------------
// ibex_rvfi_trace_buf_if
//   Groups the two bus-like port sets of the trace buffer:
//     - the RVFI retirement bundle coming out of ibex_top
//     - the valid/ready readout channel that debug logic drains
//   Modports:
//     master : drives the retirement bundle and rd_ready_i, consumes readout
//              (the core side plus the debug consumer, e.g. a testbench)
//     slave  : the trace buffer itself
// ----------------------------------------------------------------------------
interface ibex_rvfi_trace_buf_if;
    // Retirement bundle
    logic         rvfi_valid;
    logic [31:0]  rvfi_insn;
    logic         rvfi_trap;
    logic         rvfi_intr;
    logic [31:0]  rvfi_pc_rdata;
    logic [4:0]   rvfi_rd_addr;
    logic [31:0]  rvfi_rd_wdata;
    logic [31:0]  rvfi_mem_addr;
    logic [3:0]   rvfi_mem_rmask;
    logic [3:0]   rvfi_mem_wmask;

    // Readout channel
    logic         rd_valid_o;
    logic         rd_ready_i;
    logic [136:0] rd_data_o;

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rd_ready_i,
        input  rd_valid_o, rd_data_o
    );

    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rd_ready_i,
        output rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/ibex_rvfi_trace_buf.sv
// ----------------------------------------------------------------------------
// ibex_rvfi_trace_buf
//   Synthesizable RVFI retirement recorder. Captures filtered retirement
//   records into a circular buffer; after a trigger (trap or PC match) it
//   keeps PostTrigCnt further records and freezes, then debug logic drains
//   the buffer oldest-first over valid/ready.
//
// Parameters
//   Depth        buffer entries (power of 2, >= 2)
//   PostTrigCnt  records stored after the trigger record (0..Depth-1)
//   TrapTrigEn   rvfi_trap acts as a trigger source when set
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   rvfi           retirement bundle in, readout channel out (slave modport)
//   arm_i          start capture (pulse, honoured in IDLE/FROZEN)
//   clear_i        abort and empty buffer (pulse, highest priority)
//   mode_i         filter: 00 all, 01 mem ops, 10 trap|intr, 11 rd_addr!=0
//   trig_pc_en_i   enable PC-match trigger on trig_pc_i
//   state_o        00 IDLE, 01 ARMED, 10 POST, 11 FROZEN
//   count_o        number of stored records
//   overflow_o     sticky: an unread record was overwritten
//   triggered_o    sticky: trigger seen since arm
// ----------------------------------------------------------------------------
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth       = 16,
    parameter int unsigned PostTrigCnt = 8,
    parameter bit          TrapTrigEn  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    ibex_rvfi_trace_buf_if.slave    rvfi,
    input  logic                    arm_i,
    input  logic                    clear_i,
    input  logic [1:0]              mode_i,
    input  logic                    trig_pc_en_i,
    input  logic [31:0]             trig_pc_i,
    output logic [1:0]              state_o,
    output logic [$clog2(Depth):0]  count_o,
    output logic                    overflow_o,
    output logic                    triggered_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 137;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_POST   = 2'b10,
        ST_FROZEN = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q, triggered_q;

    logic [RW-1:0]   mem [Depth];
    logic [RW-1:0]   wr_rec;

    logic            filt, qual, trig, capturing, store, restart;
    logic            rd_valid, pop, full;

    // ------------------------------------------------------------------------
    // Record qualification
    // ------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default (here via a
    // full case with default) so no latch is inferred.
    always_comb begin
        filt = 1'b0;
        unique case (mode_i)
            2'b00:   filt = 1'b1;
            2'b01:   filt = (|rvfi.rvfi_mem_rmask) | (|rvfi.rvfi_mem_wmask);
            2'b10:   filt = rvfi.rvfi_trap | rvfi.rvfi_intr;
            default: filt = (rvfi.rvfi_rd_addr != 5'd0);
        endcase
    end

    assign qual = rvfi.rvfi_valid & filt;
    assign trig = rvfi.rvfi_valid &
                  ((TrapTrigEn & rvfi.rvfi_trap) |
                   (trig_pc_en_i & (rvfi.rvfi_pc_rdata == trig_pc_i)));

    assign capturing = (state_q == ST_ARMED) | (state_q == ST_POST);
    // A trigger record is kept even when the filter rejects it.
    assign store     = capturing & (qual | trig) & ~clear_i;
    // arm_i only restarts from a resting state; clear_i overrides it.
    assign restart   = arm_i & ~clear_i &
                       ((state_q == ST_IDLE) | (state_q == ST_FROZEN));

    assign full      = (count_q == CW'(Depth));
    assign rd_valid  = ((state_q == ST_FROZEN) | (state_q == ST_IDLE)) &
                       (count_q != '0);
    // Pops and stores are mutually exclusive by state.
    assign pop       = rd_valid & rvfi.rd_ready_i;

    assign wr_rec = {rvfi.rvfi_trap, rvfi.rvfi_intr, rvfi.rvfi_rd_addr,
                     |rvfi.rvfi_mem_wmask, |rvfi.rvfi_mem_rmask,
                     rvfi.rvfi_pc_rdata, rvfi.rvfi_insn,
                     rvfi.rvfi_rd_wdata, rvfi.rvfi_mem_addr};

    // ------------------------------------------------------------------------
    // Capture FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_FROZEN: begin
                    if (arm_i) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig) begin
                        post_cnt_d = '0;
                        state_d    = (PostTrigCnt == 0) ? ST_FROZEN : ST_POST;
                    end
                end
                ST_POST: begin
                    // Later triggers are ordinary records here; they only
                    // advance the post count like any other store.
                    if (store) begin
                        post_cnt_d = post_cnt_q + CW'(1);
                        if (post_cnt_q + CW'(1) == CW'(PostTrigCnt)) begin
                            state_d = ST_FROZEN;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else if (clear_i || restart) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (full) begin
                    // Ring is full: drop the oldest record to make room.
                    rd_ptr_q   <= rd_ptr_q + AW'(1);
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q  <= count_q - CW'(1);
            end
            if (state_q == ST_ARMED && trig) begin
                triggered_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count_q
    // and readout is masked while empty, so stale contents are never seen.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem[wr_ptr_q] <= wr_rec;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The oldest entry only changes on a pop, so rd_data_o is stable while
    // the consumer stalls; it reads as zero whenever nothing is offered.
    assign rvfi.rd_valid_o = rd_valid;
    assign rvfi.rd_data_o  = rd_valid ? mem[rd_ptr_q] : '0;

    assign state_o     = state_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign triggered_o = triggered_q;

endmodule
